// File: rtl/fibo_bcd_display_pkg.sv
// Shared types, constants and helpers for the Fibonacci BCD display block.
package fibo_pkg;

  localparam int BIN_W      = 16;
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  // All segments off, in each drive polarity.
  localparam logic [6:0] SEG_BLANK_AH = 7'h00;
  localparam logic [6:0] SEG_BLANK_AL = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1
  } state_e;

  // Active-high segment pattern for a decimal digit (bit0 = a .. bit6 = g).
  // Codes 10-15 cannot come out of the converter and show as blank.
  function automatic logic [6:0] seg_lut(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = SEG_BLANK_AH;
    endcase
    return seg;
  endfunction

  // Double-dabble pre-shift correction: add 3 to every nibble >= 5.
  // A 4-bit add is enough because a corrected nibble never exceeds 12.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] scratch);
    logic [BCD_W-1:0] res;
    logic [3:0]       nib;
    res = scratch;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      nib = scratch[4*i +: 4];
      if (nib >= 4'd5) begin
        res[4*i +: 4] = nib + 4'd3;
      end else begin
        res[4*i +: 4] = nib;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fibo_bcd_display_seg7.sv
// One seven-segment digit decoder with blanking and selectable drive polarity.
module seg7_decode
  import fibo_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_ah_s;

  // Select the active-high pattern, then apply the board's pin polarity.
  always_comb begin
    seg_ah_s = SEG_BLANK_AH;
    if (blank_i) begin
      seg_ah_s = SEG_BLANK_AH;
    end else begin
      seg_ah_s = seg_lut(digit_i);
    end
    if (SEG_ACTIVE_LOW != 0) begin
      seg_o = ~seg_ah_s;
    end else begin
      seg_o = seg_ah_s;
    end
  end

endmodule

// File: rtl/fibo_bcd_display.sv
// Captures a 16-bit Fibonacci result, converts it to five BCD digits with a
// sequential double-dabble datapath and drives five seven-segment digits.
module fibo_bcd_display
  import fibo_pkg::*;
#(
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bin_valid,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             bcd_valid,
  output logic [BCD_W-1:0] bcd_out,
  output logic             overrun,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [6:0]       hex4
);

  localparam logic [4:0] LAST_ITER = 5'(BIN_W - 1);

  state_e           state_q,     state_d;
  logic [BIN_W-1:0] bin_q,       bin_d;
  logic [BCD_W-1:0] scratch_q,   scratch_d;
  logic [4:0]       count_q,     count_d;
  logic [BCD_W-1:0] bcd_out_q,   bcd_out_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic             overrun_q,   overrun_d;
  logic             busy_q,      busy_d;

  logic [BCD_W-1:0] adj_s;
  logic [BCD_DIGITS-1:0] blank_s;
  logic [6:0]       seg_s [BCD_DIGITS];

  // State and datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bin_q       <= '0;
      scratch_q   <= '0;
      count_q     <= 5'd0;
      bcd_out_q   <= '0;
      bcd_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      scratch_q   <= scratch_d;
      count_q     <= count_d;
      bcd_out_q   <= bcd_out_d;
      bcd_valid_q <= bcd_valid_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  // Next state: capture in IDLE, one adjust+shift per edge in CONVERT.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    scratch_d   = scratch_q;
    count_d     = count_q;
    bcd_out_d   = bcd_out_q;
    bcd_valid_d = 1'b0;
    overrun_d   = 1'b0;
    adj_s       = dd_adjust(scratch_q);
    case (state_q)
      ST_IDLE: begin
        if (bin_valid) begin
          bin_d     = bin_in;
          scratch_d = '0;
          count_d   = 5'd0;
          state_d   = ST_CONVERT;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        // A new value cannot be taken while converting; flag the drop.
        overrun_d            = bin_valid;
        {scratch_d, bin_d}   = {adj_s[BCD_W-2:0], bin_q, 1'b0};
        count_d              = count_q + 5'd1;
        if (count_q == LAST_ITER) begin
          bcd_out_d   = {adj_s[BCD_W-2:0], bin_q[BIN_W-1]};
          bcd_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_CONVERT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_CONVERT);
  end

  // Leading-zero blanking: digit k >= 1 blanks when it and all higher digits are zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank_s    = '0;
    for (int k = BCD_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (bcd_out_q[4*k +: 4] == 4'd0);
      blank_s[k] = (BLANK_LZ != 0) && zero_above;
    end
    blank_s[0] = 1'b0;
  end

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
    seg7_decode #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_seg (
      .digit_i(bcd_out_q[4*g +: 4]),
      .blank_i(blank_s[g]),
      .seg_o  (seg_s[g])
    );
  end

  assign busy      = busy_q;
  assign bcd_valid = bcd_valid_q;
  assign bcd_out   = bcd_out_q;
  assign overrun   = overrun_q;
  assign hex0      = seg_s[0];
  assign hex1      = seg_s[1];
  assign hex2      = seg_s[2];
  assign hex3      = seg_s[3];
  assign hex4      = seg_s[4];

endmodule
